forth_stack_ctl: RTL and testbench
==================================

Name: forth_stack_ctl

Overview:
- Parametrised hardware stack for the microForth core; successor to the current data/return stack.
- Adds explicit depth tracking, full/empty flags, sticky overflow/underflow detection with clamped pointers, synchronous flush, write-through forwarding to the top-of-stack output, and a configurable signed delta width.
- Instantiated once per stack (data and return) beside the core datapath.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 512, number of entries; must be a power of two, minimum 4.
- DELTA_W, 2, width of the signed two's-complement pointer delta; legal range -2^(DELTA_W-1) .. 2^(DELTA_W-1)-1.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous flush: depth forced to 0, flags cleared.
- delta  in  DELTA_W  signed pointer adjustment applied this cycle.
- we  in  1  write wd as the new top-of-stack after the adjustment.
- wd  in  WIDTH  write data.
- rd  out  WIDTH  current top-of-stack value, registered.
- depth  out  ADDR_WIDTH+1  number of valid entries, 0..DEPTH.
- empty  out  1  depth == 0.
- full  out  1  depth == DEPTH.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.

Behaviour:
- Reset values:
  - depth = 0, rd = 0, ovf = 0, unf = 0, empty = 1, full = 0.
  - RAM contents are not reset.
- Top index: top = depth-1 (mod DEPTH). Each cycle, the candidate value is nd = depth + sext(delta).
- Legal op: 0 <= nd <= DEPTH, and (nd >= 1 or we = 0).
  - depth <= nd.
  - If we: mem[nd-1] <= wd.
- Overflow (nd > DEPTH):
  - Whole op rejected: depth unchanged, no write.
  - ovf <= 1.
- Underflow (nd < 0, or we with nd == 0):
  - depth <= 0; no write.
  - unf <= 1.
- Simultaneous overflow and underflow is impossible. Flags stay set until rst or clr.
- clr has priority over delta/we:
  - depth <= 0, ovf <= 0, unf <= 0, rd <= 0.
  - No RAM write.
- rd latency: rd reflects the post-operation top one clock after the op (same edge that updates depth).
  - If we on a legal op: rd <= wd (write-through; the RAM is not read).
  - Else if the resulting depth == 0: rd <= 0.
  - Else: rd <= mem[new_depth-1], using a synchronous RAM read addressed combinationally with the next top index.
- A multi-slot push (delta > 1) exposes stale RAM contents in the uncovered slots; this is legal and not flagged.
- empty and full are combinational decodes of the depth register.
- RAM:
  - Write port addressed by nd-1, read port by next top.
  - A same-address read/write on one edge is covered by the write-through rule; the RAM read-during-write result is don't-care.
- Async rst mid-operation: all registers return to reset values immediately; any in-flight write is not guaranteed.

Optional Feature:
- Macro STACK_HWM_EN.
- Defined:
  - Extra output port hwm [ADDR_WIDTH+1] records the maximum depth reached since the last rst/clr.
  - Updated on the same edge as depth: hwm <= max(hwm, new depth).
  - Reset and clr value 0.
- Undefined: port and register absent; no other behaviour changes.

Decomposition:
- Package forth_stack_pkg:
  - Delta encodings DELTA_NONE=0, DELTA_PUSH=+1, DELTA_POP=-1, DELTA_POP2=-2.
  - A function computing the sign-extended next depth.
- One sub-module: stack_dp_ram, a simple dual-port RAM (one sync write port, one sync read port, inferred, WIDTH × DEPTH).
- forth_stack_ctl holds the pointer, flag and forwarding logic.

Test Plan:
- After rst, push 0x1111, 0x2222, 0x3333 (delta=+1, we=1) -> rd=0x3333, depth=3; pop (delta=-1, we=0) -> rd=0x2222, depth=2.
- DEPTH=4: push 5 values 0xA0..0xA4 -> 5th push rejected, depth=4, full=1, ovf=1, rd=0xA3.
- Depth 1, delta=-2 -> depth=0, empty=1, unf=1, rd=0; clr -> ovf=unf=0.
- Depth 2 (0x10, 0x20), delta=-1 with we=1, wd=0x55 (replace NOS) -> depth=1, rd=0x55; next pop -> depth=0, rd=0.
- delta=0, we=1 on empty -> unf=1, depth=0, no write. Then rst asserted mid-sequence at depth 3 -> depth=0, rd=0 immediately.
- STACK_HWM_EN: push to depth 3, pop to 1 -> hwm=3; clr -> hwm=0.

Source files
------------

// File: rtl/forth_stack_pkg.sv
// Shared definitions for the microForth hardware stack: delta encodings,
// top-of-stack source select, and next-depth arithmetic.
package forth_stack_pkg;

   localparam int DELTA_NONE = 0;
   localparam int DELTA_PUSH = 1;
   localparam int DELTA_POP  = -1;
   localparam int DELTA_POP2 = -2;

   typedef enum logic [1:0] {
      RD_ZERO,
      RD_FWD,
      RD_RAM
   } rd_src_e;

   // Operands arrive already widened to int (delta sign-extended), so the sum
   // can go negative or past DEPTH without wrapping.
   function automatic int next_depth(input int depth, input int delta);
      return depth + delta;
   endfunction

endpackage

// File: rtl/forth_stack_ctl_if.sv
// Core <-> stack interface. The hwm port exists only when STACK_HWM_EN is defined.
interface forth_stack_ctl_if #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 512,
   parameter int DELTA_W = 2
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  clr;
   logic [DELTA_W-1:0]    delta;
   logic                  we;
   logic [WIDTH-1:0]      wd;
   logic [WIDTH-1:0]      rd;
   logic [ADDR_WIDTH:0]   depth;
   logic                  empty;
   logic                  full;
   logic                  ovf;
   logic                  unf;
`ifdef STACK_HWM_EN
   logic [ADDR_WIDTH:0]   hwm;
`endif

   modport master (
      output clr, delta, we, wd,
`ifdef STACK_HWM_EN
      input  hwm,
`endif
      input  rd, depth, empty, full, ovf, unf
   );

   modport slave (
      input  clr, delta, we, wd,
`ifdef STACK_HWM_EN
      output hwm,
`endif
      output rd, depth, empty, full, ovf, unf
   );

endinterface

// File: rtl/stack_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// Contents are not reset.
module stack_dp_ram #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/forth_stack_ctl.sv
// microForth stack controller: depth pointer, sticky ovf/unf, flush and
// write-through top-of-stack. Define STACK_HWM_EN to add the high-water mark.
module forth_stack_ctl
   import forth_stack_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 512,
   parameter int DELTA_W    = 2,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   forth_stack_ctl_if.slave  bus
);

   logic [ADDR_WIDTH:0]   depth_q, depth_n;
   logic                  ovf_q, unf_q;
   rd_src_e               rd_src_q;
   logic [WIDTH-1:0]      fwd_q;
   logic [WIDTH-1:0]      ram_q;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic                  wr_en;
   logic                  op_ovf, op_unf, op_ok;
   int                    nd;

   always_comb begin
      nd      = next_depth(int'(depth_q), int'($signed(bus.delta)));
      op_ovf  = nd > DEPTH;
      op_unf  = (nd < 0) || (bus.we && nd == 0);
      op_ok   = !op_ovf && !op_unf;
      depth_n = '0;
      if (op_ok)       depth_n = nd[ADDR_WIDTH:0];
      else if (op_ovf) depth_n = depth_q;
      wr_en   = op_ok && bus.we && !bus.clr;
      wr_addr = ADDR_WIDTH'(nd - 1);
      // Read the next top now so the RAM output lines up with the new depth.
      rd_addr = depth_n[ADDR_WIDTH-1:0] - 1'b1;
   end

   stack_dp_ram #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (bus.wd),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         rd_src_q <= RD_ZERO;
         fwd_q    <= '0;
      end else if (bus.clr) begin
         depth_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         rd_src_q <= RD_ZERO;
      end else begin
         depth_q <= depth_n;
         if (op_ovf) ovf_q <= 1'b1;
         if (op_unf) unf_q <= 1'b1;
         // A fresh write bypasses the RAM; its read-during-write is don't-care.
         if (op_ok && bus.we) begin
            rd_src_q <= RD_FWD;
            fwd_q    <= bus.wd;
         end else if (depth_n == '0) begin
            rd_src_q <= RD_ZERO;
         end else begin
            rd_src_q <= RD_RAM;
         end
      end
   end

   always_comb begin
      bus.rd = '0;
      case (rd_src_q)
         RD_FWD:  bus.rd = fwd_q;
         RD_RAM:  bus.rd = ram_q;
         default: bus.rd = '0;
      endcase
   end

   assign bus.depth = depth_q;
   assign bus.empty = (depth_q == '0);
   assign bus.full  = (depth_q == (ADDR_WIDTH+1)'(DEPTH));
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;

`ifdef STACK_HWM_EN
   logic [ADDR_WIDTH:0] hwm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   hwm_q <= '0;
      else if (bus.clr)          hwm_q <= '0;
      else if (depth_n > hwm_q)  hwm_q <= depth_n;
   end

   assign bus.hwm = hwm_q;
`endif

endmodule

// File: tb/tb_forth_stack_ctl.sv
// Directed bench for forth_stack_ctl at DEPTH=4; expected values are hand-computed.
module tb_forth_stack_ctl;

   localparam int WIDTH   = 16;
   localparam int DEPTH   = 4;
   localparam int DELTA_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   forth_stack_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELTA_W(DELTA_W)) bus ();

   forth_stack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELTA_W(DELTA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One operation on one clock edge; outputs settle by return.
   task automatic step(input int d, input bit w, input logic [WIDTH-1:0] v, input bit c);
      @(negedge clk);
      bus.delta = DELTA_W'(d);
      bus.we    = w;
      bus.wd    = v;
      bus.clr   = c;
      @(posedge clk);
      #1;
      bus.delta = '0;
      bus.we    = 1'b0;
      bus.clr   = 1'b0;
   endtask

   task automatic push(input logic [WIDTH-1:0] v);
      step(1, 1'b1, v, 1'b0);
   endtask

   task automatic pop();
      step(-1, 1'b0, '0, 1'b0);
   endtask

   task automatic flush();
      step(0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      bus.clr   = 1'b0;
      bus.delta = '0;
      bus.we    = 1'b0;
      bus.wd    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_depth", 32'(bus.depth), 0);
      chk("rst_rd",    32'(bus.rd),    0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full",  32'(bus.full),  0);
      chk("rst_ovf",   32'(bus.ovf),   0);
      chk("rst_unf",   32'(bus.unf),   0);
      @(negedge clk);
      rst = 1'b0;

      // basic push/pop
      push(16'h1111); push(16'h2222); push(16'h3333);
      chk("push3_rd",    32'(bus.rd),    32'h3333);
      chk("push3_depth", 32'(bus.depth), 3);
      pop();
      chk("pop_rd",    32'(bus.rd),    32'h2222);
      chk("pop_depth", 32'(bus.depth), 2);
      step(0, 1'b0, '0, 1'b0);
      chk("idle_rd", 32'(bus.rd), 32'h2222);

      // overflow at DEPTH=4
      flush();
      for (int i = 0; i < 4; i++) push(16'(32'hA0 + i));
      chk("fill_full", 32'(bus.full), 1);
      chk("fill_ovf",  32'(bus.ovf),  0);
      push(16'h00A4);
      chk("ovf_depth", 32'(bus.depth), 4);
      chk("ovf_full",  32'(bus.full),  1);
      chk("ovf_flag",  32'(bus.ovf),   1);
      chk("ovf_rd",    32'(bus.rd),    32'hA3);
      chk("ovf_unf",   32'(bus.unf),   0);
      pop();
      chk("ovf_pop1_rd", 32'(bus.rd), 32'hA2);
      pop(); pop();
      chk("ovf_pop3_rd",    32'(bus.rd),    32'hA0);
      chk("ovf_pop3_depth", 32'(bus.depth), 1);
      chk("ovf_sticky",     32'(bus.ovf),   1);

      // underflow by delta=-2 at depth 1
      flush();
      chk("clr_ovf", 32'(bus.ovf), 0);
      push(16'h0077);
      step(-2, 1'b0, '0, 1'b0);
      chk("unf_depth", 32'(bus.depth), 0);
      chk("unf_empty", 32'(bus.empty), 1);
      chk("unf_flag",  32'(bus.unf),   1);
      chk("unf_rd",    32'(bus.rd),    0);
      flush();
      chk("clr_unf",  32'(bus.unf), 0);
      chk("clr_ovf2", 32'(bus.ovf), 0);

      // replace NOS: delta=-1 with write
      push(16'h0010); push(16'h0020);
      step(-1, 1'b1, 16'h0055, 1'b0);
      chk("repl_depth", 32'(bus.depth), 1);
      chk("repl_rd",    32'(bus.rd),    32'h55);
      step(0, 1'b0, '0, 1'b0);
      chk("repl_ram_rd", 32'(bus.rd), 32'h55);
      pop();
      chk("repl_pop_depth", 32'(bus.depth), 0);
      chk("repl_pop_rd",    32'(bus.rd),    0);
      chk("repl_unf",       32'(bus.unf),   0);

      // write on empty with delta=0 is an underflow
      step(0, 1'b1, 16'h0099, 1'b0);
      chk("we0_unf",   32'(bus.unf),   1);
      chk("we0_depth", 32'(bus.depth), 0);
      chk("we0_rd",    32'(bus.rd),    0);

      // async reset mid-sequence
      flush();
      push(16'h0001); push(16'h0002); push(16'h0003);
      chk("pre_rst_depth", 32'(bus.depth), 3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_depth", 32'(bus.depth), 0);
      chk("arst_rd",    32'(bus.rd),    0);
      chk("arst_empty", 32'(bus.empty), 1);
      #1 rst = 1'b0;

`ifdef STACK_HWM_EN
      push(16'h0004); push(16'h0005); push(16'h0006);
      pop(); pop();
      chk("hwm_depth", 32'(bus.depth), 1);
      chk("hwm_val",   32'(bus.hwm),   3);
      flush();
      chk("hwm_clr", 32'(bus.hwm), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
